// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and imem (slave).
// One request is outstanding at a time; imem_addr is stable while imem_req is high.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem read per PC, IF/ID register,
// one-entry hold buffer for decode back-pressure and drain of stale reads after a flush.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_WAIT  | read of current pc outstanding (pc frozen until accepted)
//   ST_HOLD  | fetched word buffered, decode stalled, no request
//   ST_DRAIN | read issued before a flush still in flight; data discarded
module if_fetch_stage #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_stall,
  input  logic              flush,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  if_fetch_stage_if.master  imem
);

  typedef enum logic [1:0] {ST_WAIT, ST_HOLD, ST_DRAIN} stateT;

  stateT             state;
  logic [ADDR_W-1:0] reqAddr;
  logic [ADDR_W-1:0] holdPc;
  logic [DATA_W-1:0] holdInstr;
  logic              accept;
  logic              stallComb;

  assign accept = ~id_stall | ~if_valid;

  assign imem.imem_req  = rst_n & (state != ST_HOLD);
  assign imem.imem_addr = (state == ST_DRAIN) ? reqAddr : pc;
  assign pc_stall       = ~rst_n | stallComb;

  always_comb begin
    stallComb = 1'b1;
    if (flush) begin
      stallComb = 1'b0;
    end else begin
      case (state)
        ST_WAIT: stallComb = ~(imem.imem_ack & accept);
        ST_HOLD: stallComb = ~accept;
        default: stallComb = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      reqAddr   <= '0;
      holdPc    <= '0;
      holdInstr <= NOP_INSTR;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc     <= '0;
    end else begin
      if (state == ST_WAIT) reqAddr <= pc;

      if (flush) begin
        // Branch target loads into pc this edge; anything fetched so far is stale.
        if_valid  <= 1'b0;
        if_instr  <= NOP_INSTR;
        holdPc    <= '0;
        holdInstr <= NOP_INSTR;
        case (state)
          ST_WAIT:  state <= imem.imem_ack ? ST_WAIT : ST_DRAIN;
          ST_HOLD:  state <= ST_WAIT;
          default:  state <= imem.imem_ack ? ST_WAIT : ST_DRAIN;
        endcase
      end else begin
        case (state)
          ST_WAIT: begin
            if (imem.imem_ack) begin
              if (accept) begin
                if_valid <= 1'b1;
                if_instr <= imem.imem_rdata;
                if_pc    <= pc;
              end else begin
                holdPc    <= pc;
                holdInstr <= imem.imem_rdata;
                state     <= ST_HOLD;
              end
            end else if (accept) begin
              if_valid <= 1'b0;
              if_instr <= NOP_INSTR;
            end
          end
          ST_HOLD: begin
            if (accept) begin
              if_valid  <= 1'b1;
              if_instr  <= holdInstr;
              if_pc     <= holdPc;
              holdInstr <= NOP_INSTR;
              state     <= ST_WAIT;
            end
          end
          default: begin
            if (imem.imem_ack) state <= ST_WAIT;
            if (accept) begin
              if_valid <= 1'b0;
              if_instr <= NOP_INSTR;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory ack, pc and stalls driven by hand each cycle,
// expected values written inline.
module tb_if_fetch_stage;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] pc;
  logic              pc_stall;
  logic              flush;
  logic              id_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  int checks;
  int failures;

  if_fetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imemBus ();

  if_fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR('0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc),
    .pc_stall (pc_stall),
    .flush    (flush),
    .id_stall (id_stall),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .imem     (imemBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check combinational outputs
  task automatic drive(input logic [15:0] p, input logic f, input logic ack,
                       input logic [31:0] rd, input logic ids);
    pc                  = p;
    flush               = f;
    imemBus.imem_ack    = ack;
    imemBus.imem_rdata  = rd;
    id_stall            = ids;
    #1;
  endtask

  task automatic comb(input string tag, input logic req, input logic [15:0] addr, input logic stall);
    chk({tag, ".req"}, 32'(imemBus.imem_req), 32'(req));
    if (req) chk({tag, ".addr"}, 32'(imemBus.imem_addr), 32'(addr));
    chk({tag, ".pc_stall"}, 32'(pc_stall), 32'(stall));
  endtask

  task automatic edgeChk(input string tag, input logic v, input logic [15:0] p, input logic [31:0] ins);
    @(posedge clk);
    #1;
    chk({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    if (v) chk({tag, ".if_pc"}, 32'(if_pc), 32'(p));
    chk({tag, ".if_instr"}, if_instr, ins);
  endtask

  task automatic resetChk(input string tag);
    chk({tag, ".req"}, 32'(imemBus.imem_req), 32'd0);
    chk({tag, ".pc_stall"}, 32'(pc_stall), 32'd1);
    chk({tag, ".if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, ".if_instr"}, if_instr, 32'd0);
    chk({tag, ".if_pc"}, 32'(if_pc), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    resetChk("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: zero-latency memory, one instruction per cycle
    drive(16'h0000, 1'b0, 1'b1, 32'hA000_0000, 1'b0);
    comb("t1.c0", 1'b1, 16'h0000, 1'b0);
    edgeChk("t1.c0", 1'b1, 16'h0000, 32'hA000_0000);
    drive(16'h0004, 1'b0, 1'b1, 32'hA000_0004, 1'b0);
    comb("t1.c1", 1'b1, 16'h0004, 1'b0);
    edgeChk("t1.c1", 1'b1, 16'h0004, 32'hA000_0004);
    drive(16'h0008, 1'b0, 1'b1, 32'hA000_0008, 1'b0);
    comb("t1.c2", 1'b1, 16'h0008, 1'b0);
    edgeChk("t1.c2", 1'b1, 16'h0008, 32'hA000_0008);

    // T2: three-cycle latency -> stalls and bubbles
    for (int i = 0; i < 3; i++) begin
      drive(16'h000C, 1'b0, 1'b0, 32'h0, 1'b0);
      comb("t2.wait", 1'b1, 16'h000C, 1'b1);
      edgeChk("t2.wait", 1'b0, 16'h0000, 32'h0);
    end
    drive(16'h000C, 1'b0, 1'b1, 32'hA000_000C, 1'b0);
    comb("t2.ack", 1'b1, 16'h000C, 1'b0);
    edgeChk("t2.ack", 1'b1, 16'h000C, 32'hA000_000C);

    // T3: decode stalled when ack for 0x10 arrives -> HOLD
    drive(16'h0010, 1'b0, 1'b1, 32'hA000_0010, 1'b1);
    comb("t3.ack", 1'b1, 16'h0010, 1'b1);
    edgeChk("t3.ack", 1'b1, 16'h000C, 32'hA000_000C);
    drive(16'h0010, 1'b0, 1'b0, 32'h0, 1'b1);
    comb("t3.hold", 1'b0, 16'h0000, 1'b1);
    edgeChk("t3.hold", 1'b1, 16'h000C, 32'hA000_000C);
    drive(16'h0010, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t3.rel", 1'b0, 16'h0000, 1'b0);
    edgeChk("t3.rel", 1'b1, 16'h0010, 32'hA000_0010);

    // T4: flush while read of 0x20 pending -> DRAIN, stale data discarded
    drive(16'h0020, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t4.req", 1'b1, 16'h0020, 1'b1);
    edgeChk("t4.req", 1'b0, 16'h0000, 32'h0);
    drive(16'h0020, 1'b1, 1'b0, 32'h0, 1'b0);
    comb("t4.flush", 1'b1, 16'h0020, 1'b0);
    edgeChk("t4.flush", 1'b0, 16'h0000, 32'h0);
    drive(16'h0040, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t4.drain", 1'b1, 16'h0020, 1'b1);
    edgeChk("t4.drain", 1'b0, 16'h0000, 32'h0);
    drive(16'h0040, 1'b0, 1'b1, 32'hA000_0020, 1'b0);
    comb("t4.stale", 1'b1, 16'h0020, 1'b1);
    edgeChk("t4.stale", 1'b0, 16'h0000, 32'h0);
    drive(16'h0040, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t4.newreq", 1'b1, 16'h0040, 1'b1);
    edgeChk("t4.newreq", 1'b0, 16'h0000, 32'h0);
    drive(16'h0040, 1'b0, 1'b1, 32'hA000_0040, 1'b0);
    comb("t4.ack", 1'b1, 16'h0040, 1'b0);
    edgeChk("t4.ack", 1'b1, 16'h0040, 32'hA000_0040);

    // T5: flush with simultaneous ack and decode stall -> no HOLD
    drive(16'h0044, 1'b1, 1'b1, 32'hA000_0044, 1'b1);
    comb("t5.flush", 1'b1, 16'h0044, 1'b0);
    edgeChk("t5.flush", 1'b0, 16'h0000, 32'h0);
    drive(16'h0080, 1'b0, 1'b0, 32'h0, 1'b1);
    comb("t5.wait", 1'b1, 16'h0080, 1'b1);
    edgeChk("t5.wait", 1'b0, 16'h0000, 32'h0);
    drive(16'h0080, 1'b0, 1'b1, 32'hA000_0080, 1'b1);
    comb("t5.ack", 1'b1, 16'h0080, 1'b0);
    edgeChk("t5.ack", 1'b1, 16'h0080, 32'hA000_0080);

    // T6a: reset mid-WAIT
    drive(16'h0084, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t6a.pre", 1'b1, 16'h0084, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    resetChk("t6a.rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(16'h0090, 1'b0, 1'b0, 32'h0, 1'b0);
    comb("t6a.rel", 1'b1, 16'h0090, 1'b1);
    imemBus.imem_ack   = 1'b1;
    imemBus.imem_rdata = 32'hA000_0090;
    #1;
    comb("t6a.ack", 1'b1, 16'h0090, 1'b0);
    edgeChk("t6a.ack", 1'b1, 16'h0090, 32'hA000_0090);

    // T6b: reset mid-HOLD
    drive(16'h0094, 1'b0, 1'b1, 32'hA000_0094, 1'b1);
    comb("t6b.ack", 1'b1, 16'h0094, 1'b1);
    edgeChk("t6b.ack", 1'b1, 16'h0090, 32'hA000_0090);
    drive(16'h0094, 1'b0, 1'b0, 32'h0, 1'b1);
    comb("t6b.hold", 1'b0, 16'h0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    resetChk("t6b.rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(16'h0098, 1'b0, 1'b0, 32'h0, 1'b1);
    comb("t6b.rel", 1'b1, 16'h0098, 1'b1);
    edgeChk("t6b.rel", 1'b0, 16'h0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
